// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the small decode helpers both the control path and the bench rely on.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEFAULT_MAX_WAIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } lsu_state_e;

    // Index of the final byte of an access; the reserved size behaves as a word.
    function automatic logic [1:0] last_byte(input logic [1:0] size);
        case (size)
            SZ_BYTE: last_byte = 2'd0;
            SZ_HALF: last_byte = 2'd1;
            default: last_byte = 2'd3;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        is_misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                        ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of an assembled little-endian load value to 32 bits.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    always_comb begin
        case (size_i)
            SZ_BYTE: result_o = {{24{data_i[7] & ~unsigned_i}}, data_i[7:0]};
            SZ_HALF: result_o = {{16{data_i[15] & ~unsigned_i}}, data_i[15:0]};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator: splits byte/half/word loads and stores into a
// little-endian sequence of byte req/ack transactions, stalling until done.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  Size_i,
    input  logic        Unsigned_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o,
    output logic        Stall_o,
    output logic        Misaligned_o,
    output logic        BusErr_o,
    output logic        MemReq_o,
    output logic        MemWe_o,
    output logic [31:0] MemAddr_o,
    output logic [7:0]  MemWData_o,
    input  logic        MemAck_i,
    input  logic [7:0]  MemRData_i
);

    lsu_state_e       state_q,  state_d;
    logic [1:0]       cnt_q,    cnt_d;
    logic [CNT_W-1:0] wait_q,   wait_d;
    logic [31:0]      rdata_q,  rdata_d;
    logic             req_q,    req_d;
    logic             we_q,     we_d;
    logic [31:0]      maddr_q,  maddr_d;
    logic [7:0]       mwdata_q, mwdata_d;
    logic             berr_q,   berr_d;
    logic [1:0]       size_q,   size_d;
    logic             uns_q,    uns_d;
    logic             store_q,  store_d;
    logic [31:0]      wbuf_q,   wbuf_d;
    logic [31:0]      rbuf_q,   rbuf_d;

    logic             req_any;
    logic             mis;
    logic [1:0]       next_cnt;
    logic [CNT_W-1:0] wait_inc;
    logic [31:0]      assembled;
    logic [31:0]      ext_res;

    assign req_any  = MemRead_i | MemWrite_i;
    assign mis      = is_misaligned(Size_i, Addr_i[1:0]);
    assign next_cnt = cnt_q + 2'd1;
    assign wait_inc = wait_q + CNT_W'(1);

    // Load bytes gathered so far with the byte arriving on this ack merged in.
    always_comb begin
        assembled = rbuf_q;
        assembled[{cnt_q, 3'b000} +: 8] = MemRData_i;
    end

    load_extend u_load_extend (
        .data_i     (assembled),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (ext_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        berr_d   = 1'b0;
        size_d   = size_q;
        uns_d    = uns_q;
        store_d  = store_q;
        wbuf_d   = wbuf_q;
        rbuf_d   = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any && !mis) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = 2'd0;
                    wait_d   = '0;
                    size_d   = Size_i;
                    uns_d    = Unsigned_i;
                    store_d  = MemWrite_i;
                    wbuf_d   = WriteData_i;
                    rbuf_d   = '0;
                    req_d    = 1'b1;
                    we_d     = MemWrite_i;
                    maddr_d  = Addr_i;
                    mwdata_d = WriteData_i[7:0];
                end
            end
            ST_ACCESS: begin
                if (MemAck_i) begin
                    wait_d = '0;
                    if (!store_q) rbuf_d = assembled;
                    if (cnt_q == last_byte(size_q)) begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        if (!store_q) rdata_d = ext_res;
                    end else begin
                        cnt_d    = next_cnt;
                        maddr_d  = maddr_q + 32'd1;
                        mwdata_d = wbuf_q[{next_cnt, 3'b000} +: 8];
                    end
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == CNT_W'(MAX_WAIT)) begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        berr_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 2'd0;
            wait_q   <= '0;
            rdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            berr_q   <= berr_d;
        end
    end

    // Operand holding registers are pure data and need no reset.
    always_ff @(posedge clk_i) begin
        size_q  <= size_d;
        uns_q   <= uns_d;
        store_q <= store_d;
        wbuf_q  <= wbuf_d;
        rbuf_q  <= rbuf_d;
    end

    assign Stall_o      = ((state_q == ST_IDLE) && req_any && !mis) || (state_q == ST_ACCESS);
    assign Misaligned_o = (state_q == ST_IDLE) && req_any && mis;
    assign BusErr_o     = berr_q;
    assign ReadData_o   = rdata_q;
    assign MemReq_o     = req_q;
    assign MemWe_o      = we_q;
    assign MemAddr_o    = maddr_q;
    assign MemWData_o   = mwdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-level model predicts every cycle's
// outputs into a queue that a negedge compare process checks against the DUT.
module tb_load_store_unit;

    localparam int MAX_WAIT = 15;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [1:0]  Size_i = 2'b00;
    logic        Unsigned_i = 1'b0;
    logic [31:0] Addr_i = '0, WriteData_i = '0;
    logic [31:0] ReadData_o;
    logic        Stall_o, Misaligned_o, BusErr_o, MemReq_o, MemWe_o;
    logic [31:0] MemAddr_o;
    logic [7:0]  MemWData_o;
    logic        MemAck_i = 1'b0;
    logic [7:0]  MemRData_i = '0;

    load_store_unit #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Size_i(Size_i), .Unsigned_i(Unsigned_i), .Addr_i(Addr_i), .WriteData_i(WriteData_i),
        .ReadData_o(ReadData_o), .Stall_o(Stall_o), .Misaligned_o(Misaligned_o),
        .BusErr_o(BusErr_o), .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o),
        .MemWData_o(MemWData_o), .MemAck_i(MemAck_i), .MemRData_i(MemRData_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        stall, req, we, mis, berr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  mem [0:255];
    logic [31:0] model_rdata = '0;
    int          dly [0:3];
    int          n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            check("stall",      32'(Stall_o),      32'(e.stall));
            check("memreq",     32'(MemReq_o),     32'(e.req));
            check("misaligned", 32'(Misaligned_o), 32'(e.mis));
            check("buserr",     32'(BusErr_o),     32'(e.berr));
            check("readdata",   ReadData_o,        e.rdata);
            if (e.req) begin
                check("memaddr",  MemAddr_o,         e.addr);
                check("memwe",    32'(MemWe_o),      32'(e.we));
                if (e.we) check("memwdata", 32'(MemWData_o), 32'(e.wdata));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic stall, input logic req, input logic we, input logic mis,
                        input logic berr, input logic [31:0] addr, input logic [7:0] wdata);
        exp_t e;
        e.stall = stall; e.req = req; e.we = we; e.mis = mis; e.berr = berr;
        e.addr = addr; e.wdata = wdata; e.rdata = model_rdata;
        expq.push_back(e);
    endtask

    function automatic logic [31:0] extend(input logic [31:0] v, input int n, input logic uns);
        logic [31:0] mask, sb;
        mask = (n == 1) ? 32'hFF : (n == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        sb   = (n == 1) ? 32'h80 : (n == 2) ? 32'h8000 : 32'h8000_0000;
        v = v & mask;
        if (!uns && ((v & sb) != 0)) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_cycles(input int k);
        MemRead_i = 0; MemWrite_i = 0; MemAck_i = 0;
        for (int i = 0; i < k; i++) begin
            push(0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    // One complete access; dly[k] = cycles byte k waits before its ack.
    task automatic txn(input logic wr, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic hold_done);
        int n; logic mis; logic berr; logic [31:0] asm_v; logic [31:0] a;
        n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        mis = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        MemRead_i = !wr; MemWrite_i = wr; Size_i = size; Unsigned_i = uns;
        Addr_i = addr; WriteData_i = wdata; MemAck_i = 0;
        if (mis) begin
            push(0, 0, 0, 1, 0, 0, 0);
            tick();
            return;
        end
        push(1, 0, 0, 0, 0, 0, 0);
        tick();
        berr = 0; asm_v = 0;
        for (int k = 0; k < n && !berr; k++) begin
            a = addr + 32'(k);
            for (int w = 0; ; w++) begin
                MemAck_i   = (w == dly[k]);
                MemRData_i = MemAck_i ? mem[a[7:0]] : 8'($urandom);
                push(1, 1, wr, 0, 0, a, wdata[8*k +: 8]);
                tick();
                if (MemAck_i) begin
                    if (wr) mem[a[7:0]] = wdata[8*k +: 8];
                    else    asm_v[8*k +: 8] = MemRData_i;
                    MemAck_i = 0;
                    break;
                end
                if (w + 1 == MAX_WAIT) begin
                    berr = 1;
                    break;
                end
            end
        end
        MemAck_i = 0;
        if (!wr && !berr) model_rdata = extend(asm_v, n, uns);
        if (!hold_done) begin MemRead_i = 0; MemWrite_i = 0; end
        push(0, 0, 0, 0, berr, 0, 0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        dly = '{0, 0, 0, 0};
        tick();
        tick();
        // Reset state with rst_i still low
        push(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_i = 1;
        idle_cycles(2);

        // Word store, back-to-back acks
        txn(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0);
        check("mem10", 32'(mem[8'h10]), 32'hEF);
        check("mem11", 32'(mem[8'h11]), 32'hBE);
        check("mem12", 32'(mem[8'h12]), 32'hAD);
        check("mem13", 32'(mem[8'h13]), 32'hDE);
        idle_cycles(1);
        txn(0, 2'b00, 0, 32'h13, 0, 0);
        check("lb_signed", ReadData_o, 32'hFFFF_FFDE);
        txn(0, 2'b00, 1, 32'h13, 0, 0);
        check("lb_unsigned", ReadData_o, 32'h0000_00DE);
        txn(0, 2'b01, 0, 32'h11, 0, 0);
        idle_cycles(1);
        // Word load with byte 2 stretched
        dly = '{0, 0, 3, 0};
        txn(0, 2'b10, 0, 32'h10, 0, 0);
        check("lw_delayed", ReadData_o, 32'hDEAD_BEEF);
        // Timeout leaves the previous load result in place
        dly = '{99, 0, 0, 0};
        txn(0, 2'b00, 0, 32'h20, 0, 0);
        check("timeout_keep", ReadData_o, 32'hDEAD_BEEF);
        dly = '{0, 0, 0, 0};
        // Address wrap via reserved size
        txn(1, 2'b11, 0, 32'hFFFF_FFFF, 32'h4433_2211, 0);
        check("wrap_mem00", 32'(mem[8'h00]), 32'h22);

        // Reset in the middle of a word store
        MemWrite_i = 1; MemRead_i = 0; Size_i = 2'b10; Addr_i = 32'h40; WriteData_i = 32'hA1B2_C3D4;
        push(1, 0, 0, 0, 0, 0, 0);
        tick();
        MemAck_i = 1;
        push(1, 1, 1, 0, 0, 32'h40, 8'hD4);
        tick();
        mem[8'h40] = 8'hD4;
        MemAck_i = 0; rst_i = 0;
        push(1, 1, 1, 0, 0, 32'h41, 8'hC3);
        tick();
        rst_i = 1; MemWrite_i = 0;
        model_rdata = 0;
        push(0, 0, 0, 0, 0, 0, 0);
        tick();
        txn(1, 2'b00, 0, 32'h20, 32'h0000_0055, 0);
        txn(0, 2'b00, 1, 32'h20, 0, 0);
        check("after_reset_lb", ReadData_o, 32'h0000_0055);

        // Randomised traffic
        for (int t = 0; t < 300; t++) begin
            logic wr; logic [1:0] sz; logic [31:0] ad;
            wr = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            ad = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                             : 32'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 19))
                    0:       dly[k] = MAX_WAIT + 2;
                    1, 2, 3: dly[k] = $urandom_range(1, 4);
                    default: dly[k] = 0;
                endcase
            end
            txn(wr, sz, 1'($urandom), ad, $urandom, 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(2);
        @(negedge clk_i);
        #1;
        check("queue_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
